lsu_ctrl: RTL and testbench

Load/store control unit sitting directly upstream of the physical-memory DPI model in the NPC core. Accepts one load or store request at a time from the execute stage and checks RISC-V alignment. It drives the memory port with a word-aligned address, byte-lane write mask and lane-shifted write data, then extracts and sign/zero-extends load data. The result is returned through a valid/ready response handshake.

---
 rtl/lsu_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
//   Load/store control unit placed in front of the physical-memory model.
//   It takes one load or store at a time and checks alignment and funct3.
//   Legal requests drive one word-aligned memory access that lasts LATENCY
//   cycles. The result is returned on a valid/ready response port.
//
// Parameters
//   LATENCY    : cycles mem_valid stays high per access (1..15)
//
// Ports
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   req_*      : request channel (valid/ready, wen, addr, wdata, funct3)
//   resp_*     : response channel (valid/ready, rdata, err)
//   mem_*      : memory port (valid, raddr/rdata, wen/waddr/wdata/wmask)
// ---------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,

  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,

  output logic        mem_valid,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  // -------------------------------------------------------------------------
  // Request legality, evaluated on the incoming request in IDLE.
  // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
  // -------------------------------------------------------------------------
  logic [1:0] req_size;
  logic       req_f3_ok;
  logic       req_misaligned;
  logic       req_ok;

  always_comb begin
    req_size  = req_funct3[1:0];
    req_f3_ok = 1'b0;
    if (req_wen) begin
      req_f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                  (req_funct3 == 3'b010);
    end else begin
      req_f3_ok = !((req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                    (req_funct3 == 3'b111));
    end
    req_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    req_ok = req_f3_ok && !req_misaligned;
  end

  // -------------------------------------------------------------------------
  // Datapath helpers working on the latched request
  // -------------------------------------------------------------------------
  logic [1:0]  off;
  logic [1:0]  size_q;
  logic        in_access;
  logic        access_last;
  logic [3:0]  lane_mask;
  logic [31:0] load_shift;
  logic [31:0] load_ext;

  assign off         = addr_q[1:0];
  assign size_q      = funct3_q[1:0];
  assign in_access   = (state_q == ST_ACCESS);
  assign access_last = in_access && (cnt_q == 4'd0);

  // Byte-lane enables: a byte hits only its own lane, a half covers the
  // aligned lane pair selected by off[1], and a word covers every lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_mask[gi] = (size_q == 2'b10) ||
                           ((size_q == 2'b01) && (off[1] == LANE[1])) ||
                           ((size_q == 2'b00) && (off == LANE));
  end

  // Bring the addressed byte/half down to bit 0, then extend per funct3.
  assign load_shift = mem_rdata >> {off, 3'b000};

  always_comb begin
    load_ext = 32'h0;
    case (funct3_q)
      3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b010:  load_ext = mem_rdata;
      3'b100:  load_ext = {24'h0, load_shift[7:0]};
      3'b101:  load_ext = {16'h0, load_shift[15:0]};
      default: load_ext = 32'h0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    err_d    = err_q;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wen_d    = req_wen;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          // Stores and errors answer with zero data, so clear it up front.
          rdata_d  = 32'h0;
          if (req_ok) begin
            err_d   = 1'b0;
            cnt_d   = CNT_INIT;
            state_d = ST_ACCESS;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!wen_q) begin
            rdata_d = load_ext;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      wen_q    <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      funct3_q <= 3'b000;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign req_ready  = (state_q == ST_IDLE);

  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid && err_q;

  assign mem_valid  = in_access;
  assign mem_raddr  = {addr_q[31:2], 2'b00};
  assign mem_waddr  = {addr_q[31:2], 2'b00};
  // The write strobe fires only in the final access cycle, so a store cut
  // short by reset never reaches memory.
  assign mem_wen    = access_last && wen_q;
  assign mem_wdata  = (in_access && wen_q) ? (wdata_q << {off, 3'b000}) : 32'h0;
  assign mem_wmask  = (in_access && wen_q) ? {4'b0000, lane_mask} : 8'h00;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_ready;
  logic [31:0] mem_rdata;

  // LATENCY=1 instance
  logic        req_valid1, req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_rdata1, mem_raddr1, mem_waddr1, mem_wdata1;
  logic        mem_valid1, mem_wen1;
  logic [7:0]  mem_wmask1;

  // LATENCY=3 instance
  logic        req_valid3, req_ready3, resp_valid3, resp_err3;
  logic [31:0] resp_rdata3, mem_raddr3, mem_waddr3, mem_wdata3;
  logic        mem_valid3, mem_wen3;
  logic [7:0]  mem_wmask3;

  lsu_ctrl #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid1), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1),
    .mem_valid(mem_valid1), .mem_raddr(mem_raddr1), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen1), .mem_waddr(mem_waddr1), .mem_wdata(mem_wdata1),
    .mem_wmask(mem_wmask1)
  );

  lsu_ctrl #(.LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata3), .resp_err(resp_err3),
    .mem_valid(mem_valid3), .mem_raddr(mem_raddr3), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen3), .mem_waddr(mem_waddr3), .mem_wdata(mem_wdata3),
    .mem_wmask(mem_wmask3)
  );

  int total = 0;
  int bad   = 0;

  // Count write strobes seen on the LATENCY=3 instance.
  int wen3_cnt = 0;
  always @(negedge clk) if (mem_wen3) wen3_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wdata;
    logic [7:0]  exp_wmask;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // wen addr wdata f3 mem_rdata err exp_rdata exp_wdata exp_wmask
    vecs[0]  = '{1'b0, 32'h80000004, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 32'h0, 8'h00}; // LW
    vecs[1]  = '{1'b0, 32'h80000003, 32'h0, 3'b000, 32'h80AA5500, 1'b0, 32'hFFFFFF80, 32'h0, 8'h00}; // LB
    vecs[2]  = '{1'b0, 32'h80000003, 32'h0, 3'b100, 32'h80AA5500, 1'b0, 32'h00000080, 32'h0, 8'h00}; // LBU
    vecs[3]  = '{1'b0, 32'h80000002, 32'h0, 3'b001, 32'h80AA5500, 1'b0, 32'hFFFF80AA, 32'h0, 8'h00}; // LH
    vecs[4]  = '{1'b0, 32'h80000000, 32'h0, 3'b101, 32'h80AA5500, 1'b0, 32'h00005500, 32'h0, 8'h00}; // LHU
    vecs[5]  = '{1'b0, 32'h80000001, 32'h0, 3'b000, 32'h80AA5500, 1'b0, 32'h00000055, 32'h0, 8'h00}; // LB
    vecs[6]  = '{1'b1, 32'h80000002, 32'h1234ABCD, 3'b001, 32'h0, 1'b0, 32'h0, 32'hABCD0000, 8'h0C}; // SH
    vecs[7]  = '{1'b1, 32'h80000001, 32'h000000A5, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0000A500, 8'h02}; // SB
    vecs[8]  = '{1'b1, 32'h80000008, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, 32'h0, 32'hCAFEF00D, 8'h0F}; // SW
    vecs[9]  = '{1'b0, 32'h80000001, 32'h0, 3'b010, 32'h12345678, 1'b1, 32'h0, 32'h0, 8'h00}; // LW misaligned
    vecs[10] = '{1'b0, 32'h80000003, 32'h0, 3'b001, 32'h12345678, 1'b1, 32'h0, 32'h0, 8'h00}; // LH misaligned
    vecs[11] = '{1'b0, 32'h80000000, 32'h0, 3'b011, 32'h12345678, 1'b1, 32'h0, 32'h0, 8'h00}; // load f3 011
    vecs[12] = '{1'b1, 32'h80000000, 32'h55, 3'b100, 32'h0, 1'b1, 32'h0, 32'h0, 8'h00};       // store f3 100
    vecs[13] = '{1'b0, 32'h80000000, 32'h0, 3'b110, 32'h12345678, 1'b1, 32'h0, 32'h0, 8'h00}; // load f3 110
    vecs[14] = '{1'b1, 32'h80000002, 32'h77, 3'b010, 32'h0, 1'b1, 32'h0, 32'h0, 8'h00};       // SW misaligned

    rst = 1'b1; req_valid1 = 1'b0; req_valid3 = 1'b0; req_wen = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'b0;
    resp_ready = 1'b1; mem_rdata = 32'h0;

    // ---------------- reset values ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready",  32'(req_ready1),  32'h1);
    chk("rst_resp_valid", 32'(resp_valid1), 32'h0);
    chk("rst_resp_rdata", resp_rdata1,      32'h0);
    chk("rst_resp_err",   32'(resp_err1),   32'h0);
    chk("rst_mem_valid",  32'(mem_valid1),  32'h0);
    chk("rst_mem_wen",    32'(mem_wen1),    32'h0);
    chk("rst_mem_wmask",  32'(mem_wmask1),  32'h0);
    chk("rst_mem_wdata",  mem_wdata1,       32'h0);
    chk("rst_mem_raddr",  mem_raddr1,       32'h0);
    chk("rst_mem_waddr",  mem_waddr1,       32'h0);
    chk("rst_req_ready3", 32'(req_ready3),  32'h1);
    $display("transaction reset: checked reset state");
    rst = 1'b0;
    @(negedge clk);

    // ---------------- table-driven vectors on LATENCY=1 ----------------
    for (int i = 0; i < 15; i++) begin
      req_wen    = vecs[i].wen;
      req_addr   = vecs[i].addr;
      req_wdata  = vecs[i].wdata;
      req_funct3 = vecs[i].f3;
      mem_rdata  = vecs[i].rdata;
      resp_ready = 1'b1;
      req_valid1 = 1'b1;
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready1), 32'h1);
      @(posedge clk);           // handshake edge 0
      @(negedge clk);           // cycle 1
      req_valid1 = 1'b0;
      if (vecs[i].err) begin
        chk($sformatf("v%0d_c1_resp_valid", i), 32'(resp_valid1), 32'h1);
        chk($sformatf("v%0d_c1_resp_err", i),   32'(resp_err1),   32'h1);
        chk($sformatf("v%0d_c1_resp_rdata", i), resp_rdata1,      32'h0);
        chk($sformatf("v%0d_c1_mem_valid", i),  32'(mem_valid1),  32'h0);
        chk($sformatf("v%0d_c1_mem_wen", i),    32'(mem_wen1),    32'h0);
      end else begin
        chk($sformatf("v%0d_c1_mem_valid", i),  32'(mem_valid1),  32'h1);
        chk($sformatf("v%0d_c1_mem_raddr", i),  mem_raddr1, {vecs[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_c1_mem_waddr", i),  mem_waddr1, {vecs[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_c1_mem_wen", i),    32'(mem_wen1),    32'(vecs[i].wen));
        chk($sformatf("v%0d_c1_mem_wmask", i),  32'(mem_wmask1),  32'(vecs[i].exp_wmask));
        if (vecs[i].wen)
          chk($sformatf("v%0d_c1_mem_wdata", i), mem_wdata1, vecs[i].exp_wdata);
        chk($sformatf("v%0d_c1_resp_valid", i), 32'(resp_valid1), 32'h0);
        @(posedge clk);
        @(negedge clk);         // cycle 2
        chk($sformatf("v%0d_c2_resp_valid", i), 32'(resp_valid1), 32'h1);
        chk($sformatf("v%0d_c2_resp_err", i),   32'(resp_err1),   32'h0);
        chk($sformatf("v%0d_c2_resp_rdata", i), resp_rdata1,      vecs[i].exp_rdata);
        chk($sformatf("v%0d_c2_mem_valid", i),  32'(mem_valid1),  32'h0);
        chk($sformatf("v%0d_c2_mem_wen", i),    32'(mem_wen1),    32'h0);
      end
      @(posedge clk);           // response handshake
      @(negedge clk);
      chk($sformatf("v%0d_idle_resp_valid", i), 32'(resp_valid1), 32'h0);
      chk($sformatf("v%0d_idle_req_ready", i),  32'(req_ready1),  32'h1);
      $display("transaction vec %0d: wen=%0d addr=%h f3=%b rdata=%h err=%0d",
               i, vecs[i].wen, vecs[i].addr, vecs[i].f3, resp_rdata1, resp_err1);
    end

    // ---------------- LATENCY=3 store with response stall ----------------
    req_wen = 1'b1; req_addr = 32'h80000010; req_wdata = 32'h11223344;
    req_funct3 = 3'b010; resp_ready = 1'b0; req_valid3 = 1'b1;
    @(posedge clk);             // edge 0
    @(negedge clk);
    // keep requesting with different fields while busy: must be ignored
    req_addr = 32'h80000020; req_wdata = 32'h99999999;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("l3_c%0d_mem_valid", c), 32'(mem_valid3), 32'h1);
      chk($sformatf("l3_c%0d_mem_waddr", c), mem_waddr3, 32'h80000010);
      chk($sformatf("l3_c%0d_mem_wen", c),   32'(mem_wen3), (c == 3) ? 32'h1 : 32'h0);
      chk($sformatf("l3_c%0d_req_ready", c), 32'(req_ready3), 32'h0);
      chk($sformatf("l3_c%0d_resp_valid", c), 32'(resp_valid3), 32'h0);
      if (c == 3) begin
        chk("l3_c3_mem_wmask", 32'(mem_wmask3), 32'h0F);
        chk("l3_c3_mem_wdata", mem_wdata3, 32'h11223344);
      end
      @(posedge clk);
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("l3_stall%0d_resp_valid", k), 32'(resp_valid3), 32'h1);
      chk($sformatf("l3_stall%0d_resp_err", k),   32'(resp_err3),   32'h0);
      chk($sformatf("l3_stall%0d_mem_valid", k),  32'(mem_valid3),  32'h0);
      chk($sformatf("l3_stall%0d_mem_wen", k),    32'(mem_wen3),    32'h0);
      chk($sformatf("l3_stall%0d_req_ready", k),  32'(req_ready3),  32'h0);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid3 = 1'b0;
    resp_ready = 1'b1;
    chk("l3_pre_hs_resp_valid", 32'(resp_valid3), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("l3_post_hs_resp_valid", 32'(resp_valid3), 32'h0);
    chk("l3_post_hs_req_ready",  32'(req_ready3),  32'h1);
    chk("l3_wen_pulses", 32'(wen3_cnt), 32'h1);
    $display("transaction lat3 SW stall: wen pulses=%0d", wen3_cnt);

    // ---------------- reset in the middle of a LATENCY=3 store ----------------
    wen3_cnt = 0;
    req_wen = 1'b1; req_addr = 32'h80000014; req_wdata = 32'hA5A5A5A5;
    req_funct3 = 3'b010; req_valid3 = 1'b1;
    @(posedge clk);             // edge 0
    @(negedge clk);             // access cycle 1
    req_valid3 = 1'b0;
    chk("rstmid_c1_mem_valid", 32'(mem_valid3), 32'h1);
    @(posedge clk);
    @(negedge clk);             // access cycle 2
    chk("rstmid_c2_mem_wen", 32'(mem_wen3), 32'h0);
    rst = 1'b1;
    #1;
    chk("rstmid_req_ready",  32'(req_ready3),  32'h1);
    chk("rstmid_mem_valid",  32'(mem_valid3),  32'h0);
    chk("rstmid_resp_valid", 32'(resp_valid3), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstmid_resp_valid_after", 32'(resp_valid3), 32'h0);
    chk("rstmid_no_wen", 32'(wen3_cnt), 32'h0);
    $display("transaction reset mid-store: wen pulses=%0d", wen3_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
